// File: rtl/ssd_scan_driver.sv
// Six-digit multiplexed seven-segment driver: frame-synchronous snapshot of the digit codes,
// registered active-low anode/segment/decimal-point outputs. Optional blink of encrypted digits via SSD_BLINK_EN.
module ssd_scan_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 32
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] NumIn1,
    input  logic [3:0] NumIn2,
    input  logic [3:0] NumIn3,
    input  logic [3:0] NumIn4,
    input  logic [3:0] NumIn5,
    input  logic [3:0] NumIn6,
    input  logic       Encrypt_in1,
    input  logic       Encrypt_in2,
    input  logic       Encrypt_in3,
    input  logic       Encrypt_in4,
    input  logic       Encrypt_in5,
    input  logic       Encrypt_in6,
    output logic [5:0] An,
    output logic [6:0] Seg,
    output logic       Dp
);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

    logic [PRE_W-1:0] pre_reg;
    logic [2:0]       idx_reg;
    logic             load_pending_reg;
    logic [3:0]       code_reg [6];
    logic             flag_reg [6];
    logic [3:0]       num_in [6];
    logic             enc_in [6];
    logic [5:0]       an_reg;
    logic [6:0]       seg_reg;
    logic             dp_reg;
    logic [5:0]       an_sel;
    logic [5:0]       an_next;
    logic [6:0]       seg_next;
    logic             dp_next;
    logic [3:0]       cur_code;
    logic             cur_flag;
    logic             slot_end;
    logic             frame_end;
    logic             blink_phase;

    assign num_in[0] = NumIn1;
    assign num_in[1] = NumIn2;
    assign num_in[2] = NumIn3;
    assign num_in[3] = NumIn4;
    assign num_in[4] = NumIn5;
    assign num_in[5] = NumIn6;
    assign enc_in[0] = Encrypt_in1;
    assign enc_in[1] = Encrypt_in2;
    assign enc_in[2] = Encrypt_in3;
    assign enc_in[3] = Encrypt_in4;
    assign enc_in[4] = Encrypt_in5;
    assign enc_in[5] = Encrypt_in6;

    assign slot_end  = (pre_reg == PRE_LAST);
    assign frame_end = slot_end && (idx_reg == 3'd5);

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_anode
            assign an_sel[gi] = (idx_reg != 3'(gi));
        end
    endgenerate

    function automatic logic [6:0] hex_glyph(input logic [3:0] code);
        case (code)
            4'h0: hex_glyph = 7'b1000000;
            4'h1: hex_glyph = 7'b1111001;
            4'h2: hex_glyph = 7'b0100100;
            4'h3: hex_glyph = 7'b0110000;
            4'h4: hex_glyph = 7'b0011001;
            4'h5: hex_glyph = 7'b0010010;
            4'h6: hex_glyph = 7'b0000010;
            4'h7: hex_glyph = 7'b1111000;
            4'h8: hex_glyph = 7'b0000000;
            4'h9: hex_glyph = 7'b0010000;
            4'hA: hex_glyph = 7'b0001000;
            4'hB: hex_glyph = 7'b0000011;
            4'hC: hex_glyph = 7'b1000110;
            4'hD: hex_glyph = 7'b0100001;
            4'hE: hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    // Counters and snapshot; the bank only samples the inputs at reset release and frame wrap.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pre_reg          <= '0;
            idx_reg          <= '0;
            load_pending_reg <= 1'b1;
            for (int i = 0; i < 6; i++) begin
                code_reg[i] <= 4'hF;
                flag_reg[i] <= 1'b1;
            end
        end else begin
            pre_reg <= slot_end ? '0 : pre_reg + 1'b1;
            if (slot_end) begin
                idx_reg <= (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
            end
            load_pending_reg <= 1'b0;
            if (load_pending_reg || frame_end) begin
                for (int i = 0; i < 6; i++) begin
                    code_reg[i] <= num_in[i];
                    flag_reg[i] <= enc_in[i];
                end
            end
        end
    end

`ifdef SSD_BLINK_EN
    localparam int FC_W = $clog2(BLINK_FRAMES + 1);
    logic [FC_W-1:0] frame_cnt_reg;
    logic            blink_phase_reg;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt_reg == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_reg   <= '0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
        end
    end
    assign blink_phase = blink_phase_reg;
`else
    logic unused_blink;
    assign unused_blink = (BLINK_FRAMES == 0);
    assign blink_phase  = 1'b0;
`endif

    always_comb begin
        cur_code = 4'hF;
        cur_flag = 1'b1;
        an_next  = 6'b111111;
        seg_next = 7'b1111111;
        dp_next  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (idx_reg == 3'(i)) begin
                cur_code = code_reg[i];
                cur_flag = flag_reg[i];
            end
        end
        // Dead time at the head of each slot keeps the previous digit from ghosting.
        if (int'(pre_reg) >= BLANK_CYC) begin
            an_next = an_sel;
            if (!(cur_flag && ((cur_code == 4'hF) || blink_phase))) begin
                seg_next = hex_glyph(cur_code);
                dp_next  = ~cur_flag;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            an_reg  <= 6'b111111;
            seg_reg <= 7'b1111111;
            dp_reg  <= 1'b1;
        end else begin
            an_reg  <= an_next;
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
        end
    end

    assign An  = an_reg;
    assign Seg = seg_reg;
    assign Dp  = dp_reg;

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Time-multiplexed six-digit seven-segment display driver. It is the consumer of the six `NumOut`/`Encrypt_on` pairs produced by the level-dependent digit router. Each frame it captures the six digit codes, then scans them one at a time onto shared active-low segment lines and active-low anode selects. Encrypted digits are marked with the decimal point, and code 15 with the encrypt flag set renders as blank.

## Interface
Parameters:
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; legal values are ≥ 2.
- `BLANK_CYC`, default 500: anti-ghosting dead cycles at the start of each slot; legal values are < `REFRESH_DIV`.
- `BLINK_FRAMES`, default 32: frames per blink half-period. Used only when `SSD_BLINK_EN` is defined.

Ports:
- `Clk`, input, 1: the single clock; all state updates on the rising edge.
- `Rst`, input, 1: asynchronous reset, active-high.
- `NumIn1`..`NumIn6`, input, 4 each: digit codes 0–15; `NumIn1` is the leftmost digit.
- `Encrypt_in1`..`Encrypt_in6`, input, 1 each: per-digit encrypt/blank flag.
- `An`, output, 6: anode selects, active-low; `An[0]` selects digit 1.
- `Seg`, output, 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `Dp`, output, 1: decimal point, active-low.

## Operation
- `pre` is the prescaler: counts 0..`REFRESH_DIV`-1, then wraps to 0.
- `idx` is the digit index: counts 0..5 and advances when `pre`==`REFRESH_DIV`-1. After 5 it wraps to 0.
- One frame is 6×`REFRESH_DIV` cycles.
- Snapshot bank: six registered (code, flag) pairs. Load conditions:
  - The bank loads from the inputs on the edge where `idx` wraps 5→0.
  - It also loads on the first rising edge after `Rst` deasserts. A `load_pending` flag, set by reset, drives this load.
  - Inputs are never sampled at any other time. Mid-frame input changes therefore cannot tear the display.
- Glyph decode, applied to the snapshot entry at `idx`:
  - Flag 0: hex glyph for the code, `Dp`=1. Examples: 0→1000000, 1→1111001, 2→0100100, 7→1111000, 8→0000000, F→0001110.
  - Flag 1, code 15: blank, `Seg`=1111111, `Dp`=1.
  - Flag 1, any other code: hex glyph with `Dp`=0, marking the digit as encrypted.
- Dead time: while `pre` < `BLANK_CYC`, `An`=111111, `Seg`=1111111 and `Dp`=1.
- Otherwise `An` is a one-cold code with the bit at `idx` low.

## Timing
- Reset values, applied immediately and without waiting for a clock edge:
  - `An`=111111, `Seg`=1111111, `Dp`=1.
  - `pre`=0, `idx`=0, `load_pending`=1.
  - Snapshot all (15, 1), i.e. blank.
  - Blink phase 0, frame counter 0.
- `An`, `Seg` and `Dp` are registered. They reflect the `pre`/`idx`/snapshot state of the previous cycle, so there is 1-cycle latency from counter state to pins.
- Input-to-pin latency is ≤ 1 frame + 2 cycles:
  - Input change to snapshot load: up to one frame.
  - Load to pin: 1 cycle.
- First frame after reset:
  - The snapshot loads at the first edge.
  - Digit 1 is lit from cycle `BLANK_CYC`+1 onward.
- Reset asserted mid-slot or mid-frame:
  - Outputs go to reset values asynchronously.
  - The scan restarts at digit 1 with a fresh snapshot load after release.
- A snapshot load and an `idx` wrap happen on the same edge. Slot 0 of the new frame therefore uses the new snapshot.

## Configuration
- Macro: `SSD_BLINK_EN`.
- Defined:
  - A frame counter counts completed frames (`idx` 5→0 wraps).
  - Blink phase toggles every `BLINK_FRAMES` frames.
  - While phase=1, digits with flag 1 and code ≠ 15 drive `Seg`=1111111 and `Dp`=1. Their anode is still asserted.
  - Flag-0 digits are unaffected.
- Undefined: no frame counter or phase logic; encrypted digits are always shown.

## Test plan
Benches use `REFRESH_DIV`=4 and `BLANK_CYC`=1.
- **Reset values.** Hold `Rst`=1 for 5 cycles → `An`=111111, `Seg`=1111111, `Dp`=1 throughout.
- **Basic scan.** Set `NumIn1`..`NumIn6`=1,2,3,4,5,6, all flags 0, release reset → expected, repeating every 24 cycles:
  - 1 dead cycle, then 3 cycles of `An`=111110, `Seg`=1111001.
  - 1 dead cycle, then 3 cycles of `An`=111101, `Seg`=0100100.
- **No tearing.** Change `NumIn1` from 1 to 8 during slot 3 → digit 1 shows 1111001 for the rest of that frame, and 0000000 from the next frame onward.
- **Encrypt flags.**
  - `NumIn3`=15 with `Encrypt_in3`=1 → slot 3 has `An`=111011, `Seg`=1111111, `Dp`=1.
  - `NumIn4`=7 with `Encrypt_in4`=1 → slot 4 has `Seg`=1111000, `Dp`=0.
- **Async reset mid-slot.** Assert `Rst` between clock edges during slot 2 → pins go to reset values before the next edge. After release, the scan restarts at `An`=111110.
- **Blink** (`SSD_BLINK_EN`, `BLINK_FRAMES`=2). Set `NumIn2`=5 with `Encrypt_in2`=1 → digit 2 alternates between `Seg`=0010010/`Dp`=0 and blank every 2 frames. A flag-0 digit stays steady.
